// File: rtl/prog_fsm_pkg.sv
// Shared constants for the table-driven FSM engine: default widths,
// entry layout and output-mode encodings.
package prog_fsm_pkg;

   // Default widths (match the original fixed 3-bit-state / 2-bit-input machines)
   localparam int DEF_IN_W    = 2;
   localparam int DEF_ST_W    = 3;
   localparam int DEF_OUT_W   = 3;
   localparam int DEF_DWELL_W = 4;

   // Entry layout is {next[ST_W], out[OUT_W]}: out sits at bit 0 and next
   // starts right above it, so the next-field offset is OUT_W.
   localparam int ENT_OUT_LSB = 0;

   // Output mode encodings for the MEALY parameter
   localparam int MODE_MOORE = 0;
   localparam int MODE_MEALY = 1;

   // Bit offset of the next-state field for a given output width
   function automatic int ent_next_lsb(input int out_w);
      return ENT_OUT_LSB + out_w;
   endfunction

endpackage

// File: rtl/prog_fsm_table.sv
// Transition table: storage array plus per-entry valid bits. Asynchronous
// read, synchronous write, bulk invalidate. Reset only clears valid bits.
module prog_fsm_table
   import prog_fsm_pkg::*;
#(
   parameter int ST_W  = DEF_ST_W,
   parameter int IN_W  = DEF_IN_W,
   parameter int OUT_W = DEF_OUT_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 we_i,
   input  logic [ST_W+IN_W-1:0] waddr_i,
   input  logic [ST_W-1:0]      wnext_i,
   input  logic [OUT_W-1:0]     wout_i,
   input  logic                 clr_i,
   input  logic [ST_W+IN_W-1:0] raddr_i,
   output logic [ST_W-1:0]      rnext_o,
   output logic [OUT_W-1:0]     rout_o,
   output logic                 rvalid_o
);

   localparam int AW       = ST_W + IN_W;
   localparam int DEPTH    = 1 << AW;
   localparam int ENT_W    = ST_W + OUT_W;
   localparam int NEXT_LSB = ent_next_lsb(OUT_W);

   logic [ENT_W-1:0] mem_q [DEPTH];
   logic [DEPTH-1:0] valid_q, valid_d;
   logic [ENT_W-1:0] rent;

   // Entry data: plain storage, deliberately left untouched by reset
   always_ff @(posedge clk) begin
      if (we_i) mem_q[waddr_i] <= {wnext_i, wout_i};
   end

   // Valid-bit next state: clear first so a same-edge write survives it
   always_comb begin
      valid_d = valid_q;
      if (clr_i) valid_d = '0;
      if (we_i)  valid_d[waddr_i] = 1'b1;
   end

   // Valid-bit register, invalidated on reset
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) valid_q <= '0;
      else        valid_q <= valid_d;
   end

   // Asynchronous read sees pre-edge contents, giving read-before-write
   assign rent     = mem_q[raddr_i];
   assign rnext_o  = rent[NEXT_LSB +: ST_W];
   assign rout_o   = rent[ENT_OUT_LSB +: OUT_W];
   assign rvalid_o = valid_q[raddr_i];

endmodule

// File: rtl/prog_fsm.sv
// Runtime-programmable FSM engine: state, sticky error, dwell counter and
// Moore/Mealy output around a writable transition table.
module prog_fsm
   import prog_fsm_pkg::*;
#(
   parameter int IN_W        = DEF_IN_W,
   parameter int ST_W        = DEF_ST_W,
   parameter int OUT_W       = DEF_OUT_W,
   parameter int RESET_STATE = 0,
   parameter int MEALY       = MODE_MOORE,
   parameter int DWELL_W     = DEF_DWELL_W
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 en,
   input  logic [IN_W-1:0]      a,
   output logic [OUT_W-1:0]     saida,
   output logic [ST_W-1:0]      estado,
   input  logic                 cfg_we,
   input  logic [ST_W+IN_W-1:0] cfg_addr,
   input  logic [ST_W-1:0]      cfg_next,
   input  logic [OUT_W-1:0]     cfg_out,
   input  logic                 cfg_clr,
   output logic                 err,
   input  logic                 err_clr,
   output logic [DWELL_W-1:0]   dwell
);

   localparam logic [ST_W-1:0]    RST_ST    = ST_W'(RESET_STATE);
   localparam logic [DWELL_W-1:0] DWELL_MAX = '1;

   logic [ST_W-1:0]      state_q, state_d;
   logic                 err_q, err_d;
   logic [DWELL_W-1:0]   dwell_q, dwell_d;
   logic [ST_W+IN_W-1:0] idx;
   logic [ST_W-1:0]      rd_next;
   logic [OUT_W-1:0]     rd_out;
   logic                 rd_valid;
   logic                 step_ok, step_bad;

   assign idx      = {state_q, a};
   assign step_ok  = en &  rd_valid;
   assign step_bad = en & ~rd_valid;

   prog_fsm_table #(
      .ST_W (ST_W),
      .IN_W (IN_W),
      .OUT_W(OUT_W)
   ) u_table (
      .clk     (clk),
      .reset   (reset),
      .we_i    (cfg_we),
      .waddr_i (cfg_addr),
      .wnext_i (cfg_next),
      .wout_i  (cfg_out),
      .clr_i   (cfg_clr),
      .raddr_i (idx),
      .rnext_o (rd_next),
      .rout_o  (rd_out),
      .rvalid_o(rd_valid)
   );

   // Next state, sticky error (set beats clear) and saturating dwell count
   always_comb begin
      state_d = state_q;
      err_d   = err_q;
      dwell_d = dwell_q;
      if (err_clr) err_d = 1'b0;
      if (step_ok) begin
         state_d = rd_next;
         if (rd_next == state_q)
            dwell_d = (dwell_q == DWELL_MAX) ? dwell_q : dwell_q + DWELL_W'(1);
         else
            dwell_d = '0;
      end else if (step_bad) begin
         state_d = RST_ST;
         err_d   = 1'b1;
         dwell_d = '0;
      end
   end

   // Sequencer registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= RST_ST;
         err_q   <= 1'b0;
         dwell_q <= '0;
      end else begin
         state_q <= state_d;
         err_q   <= err_d;
         dwell_q <= dwell_d;
      end
   end

   generate
      if (MEALY == MODE_MEALY) begin : g_mealy
         // Combinational output follows a and estado, regardless of en
         always_comb begin
            saida = '0;
            if (rd_valid) saida = rd_out;
         end
      end else begin : g_moore
         logic [OUT_W-1:0] out_q, out_d;

         // Moore output loads with the state: entry out on valid, 0 on invalid
         always_comb begin
            out_d = out_q;
            if (step_ok)       out_d = rd_out;
            else if (step_bad) out_d = '0;
         end

         // Moore output register
         always_ff @(posedge clk or negedge reset) begin
            if (!reset) out_q <= '0;
            else        out_q <= out_d;
         end

         assign saida = out_q;
      end
   endgenerate

   assign estado = state_q;
   assign err    = err_q;
   assign dwell  = dwell_q;

endmodule

// File: tb/tb_prog_fsm.sv
// Directed bench for prog_fsm: a Moore instance for sequencing, error,
// dwell and collision cases, and a Mealy instance for combinational output.
module tb_prog_fsm;

   logic       clk = 1'b0;
   logic       reset;

   // Moore instance signals
   logic       en, cfg_we, cfg_clr, err_clr;
   logic [1:0] a;
   logic [4:0] cfg_addr;
   logic [2:0] cfg_next, cfg_out;
   logic [2:0] saida, estado;
   logic       err;
   logic [3:0] dwell;

   // Mealy instance signals
   logic       m_en, m_we, m_clr, m_err_clr;
   logic [1:0] m_a;
   logic [4:0] m_addr;
   logic [2:0] m_next, m_out;
   logic [2:0] m_saida, m_estado;
   logic       m_err;
   logic [3:0] m_dwell;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   prog_fsm dut (
      .clk(clk), .reset(reset), .en(en), .a(a), .saida(saida), .estado(estado),
      .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_next(cfg_next), .cfg_out(cfg_out),
      .cfg_clr(cfg_clr), .err(err), .err_clr(err_clr), .dwell(dwell)
   );

   prog_fsm #(.MEALY(1)) dut_m (
      .clk(clk), .reset(reset), .en(m_en), .a(m_a), .saida(m_saida), .estado(m_estado),
      .cfg_we(m_we), .cfg_addr(m_addr), .cfg_next(m_next), .cfg_out(m_out),
      .cfg_clr(m_clr), .err(m_err), .err_clr(m_err_clr), .dwell(m_dwell)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Write one Moore-instance entry with en=0
   task automatic wr(input logic [2:0] st, input logic [1:0] in, input logic [2:0] nx,
                     input logic [2:0] o);
      en = 1'b0; cfg_we = 1'b1; cfg_addr = {st, in}; cfg_next = nx; cfg_out = o;
      tick();
      cfg_we = 1'b0;
   endtask

   // Single enabled step with symbol s
   task automatic stp(input logic [1:0] s);
      en = 1'b1; a = s;
      tick();
      en = 1'b0;
   endtask

   task automatic test_reset();
      wr(3'd0, 2'd0, 3'd1, 3'd5);
      stp(2'd0);
      checks++;
      if (estado !== 3'd1) begin errors++; $display("FAIL pre_reset_estado got %0d exp 1", estado); end
      #2 reset = 1'b0;
      #1;
      checks++;
      if (estado !== 3'd0 || saida !== 3'd0 || err !== 1'b0 || dwell !== 4'd0) begin
         errors++;
         $display("FAIL reset_async got st=%0d out=%0d err=%b dw=%0d exp 0/0/0/0", estado, saida, err, dwell);
      end
      #3 reset = 1'b1;
      @(negedge clk);
      stp(2'd0);
      checks++;
      if (err !== 1'b1 || estado !== 3'd0) begin
         errors++; $display("FAIL reset_invalidates got err=%b st=%0d exp 1/0", err, estado);
      end
   endtask

   task automatic test_program();
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clr_alone got %b exp 0", err); end
      wr(3'd0, 2'd0, 3'd1, 3'd5);
      wr(3'd1, 2'd2, 3'd4, 3'd2);
      stp(2'd0);
      checks++;
      if (estado !== 3'd1 || saida !== 3'd5 || dwell !== 4'd0) begin
         errors++; $display("FAIL step1 got st=%0d out=%0d dw=%0d exp 1/5/0", estado, saida, dwell);
      end
      stp(2'd2);
      checks++;
      if (estado !== 3'd4 || saida !== 3'd2) begin
         errors++; $display("FAIL step2 got st=%0d out=%0d exp 4/2", estado, saida);
      end
      // en=0 holds state and output
      a = 2'd3; tick();
      checks++;
      if (estado !== 3'd4 || saida !== 3'd2) begin
         errors++; $display("FAIL en0_hold got st=%0d out=%0d exp 4/2", estado, saida);
      end
   endtask

   task automatic test_unprog();
      stp(2'd3);
      checks++;
      if (estado !== 3'd0 || saida !== 3'd0 || err !== 1'b1) begin
         errors++; $display("FAIL unprog got st=%0d out=%0d err=%b exp 0/0/1", estado, saida, err);
      end
      err_clr = 1'b1; tick();
      checks++;
      if (err !== 1'b0) begin errors++; $display("FAIL err_clr got %b exp 0", err); end
      en = 1'b1; a = 2'd3; tick(); en = 1'b0; err_clr = 1'b0;
      checks++;
      if (err !== 1'b1 || estado !== 3'd0) begin
         errors++; $display("FAIL err_set_wins got err=%b st=%0d exp 1/0", err, estado);
      end
   endtask

   task automatic test_dwell();
      wr(3'd2, 2'd1, 3'd2, 3'd7);
      wr(3'd0, 2'd1, 3'd2, 3'd6);
      wr(3'd2, 2'd0, 3'd0, 3'd1);
      stp(2'd1);
      checks++;
      if (estado !== 3'd2 || saida !== 3'd6 || dwell !== 4'd0) begin
         errors++; $display("FAIL dwell_enter got st=%0d out=%0d dw=%0d exp 2/6/0", estado, saida, dwell);
      end
      for (int k = 1; k <= 20; k++) begin
         stp(2'd1);
         checks++;
         if (dwell !== 4'((k > 15) ? 15 : k) || saida !== 3'd7) begin
            errors++; $display("FAIL dwell_%0d got dw=%0d out=%0d exp %0d/7", k, dwell, saida, (k > 15) ? 15 : k);
         end
      end
      stp(2'd0);
      checks++;
      if (estado !== 3'd0 || dwell !== 4'd0 || saida !== 3'd1) begin
         errors++; $display("FAIL dwell_leave got st=%0d dw=%0d out=%0d exp 0/0/1", estado, dwell, saida);
      end
   endtask

   task automatic test_collision();
      // (0,0)->{1,5} still programmed; rewrite it on a step edge
      en = 1'b1; a = 2'd0; cfg_we = 1'b1; cfg_addr = 5'b000_00; cfg_next = 3'd3; cfg_out = 3'd4;
      tick();
      en = 1'b0; cfg_we = 1'b0;
      checks++;
      if (estado !== 3'd1 || saida !== 3'd5) begin
         errors++; $display("FAIL coll_old got st=%0d out=%0d exp 1/5", estado, saida);
      end
      wr(3'd1, 2'd1, 3'd0, 3'd0);
      stp(2'd1);
      stp(2'd0);
      checks++;
      if (estado !== 3'd3 || saida !== 3'd4) begin
         errors++; $display("FAIL coll_new got st=%0d out=%0d exp 3/4", estado, saida);
      end
      // Clear plus write: only (0,1) survives
      cfg_clr = 1'b1; cfg_we = 1'b1; cfg_addr = 5'b000_01; cfg_next = 3'd0; cfg_out = 3'd2;
      tick();
      cfg_clr = 1'b0; cfg_we = 1'b0;
      stp(2'd3);
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      stp(2'd0);
      checks++;
      if (err !== 1'b1 || estado !== 3'd0) begin
         errors++; $display("FAIL clr_invalidates got err=%b st=%0d exp 1/0", err, estado);
      end
      err_clr = 1'b1; tick(); err_clr = 1'b0;
      stp(2'd1);
      checks++;
      if (err !== 1'b0 || saida !== 3'd2 || dwell !== 4'd1) begin
         errors++; $display("FAIL clr_write_wins got err=%b out=%0d dw=%0d exp 0/2/1", err, saida, dwell);
      end
      // Step on the clear edge still sees the pre-clear valid bits
      cfg_clr = 1'b1; en = 1'b1; a = 2'd1;
      tick();
      cfg_clr = 1'b0; en = 1'b0;
      checks++;
      if (err !== 1'b0 || saida !== 3'd2 || dwell !== 4'd2) begin
         errors++; $display("FAIL clr_step_old got err=%b out=%0d dw=%0d exp 0/2/2", err, saida, dwell);
      end
      stp(2'd1);
      checks++;
      if (err !== 1'b1 || saida !== 3'd0 || dwell !== 4'd0) begin
         errors++; $display("FAIL clr_after got err=%b out=%0d dw=%0d exp 1/0/0", err, saida, dwell);
      end
   endtask

   task automatic test_mealy();
      m_we = 1'b1; m_addr = 5'b000_01; m_next = 3'd5; m_out = 3'd3;
      tick();
      m_we = 1'b0;
      m_a = 2'd1; #1;
      checks++;
      if (m_saida !== 3'd3 || m_estado !== 3'd0) begin
         errors++; $display("FAIL mealy_prog got out=%0d st=%0d exp 3/0", m_saida, m_estado);
      end
      m_a = 2'd2; #1;
      checks++;
      if (m_saida !== 3'd0) begin errors++; $display("FAIL mealy_unprog got %0d exp 0", m_saida); end
      m_a = 2'd1; #1;
      checks++;
      if (m_saida !== 3'd3) begin errors++; $display("FAIL mealy_back got %0d exp 3", m_saida); end
      tick();
      checks++;
      if (m_estado !== 3'd0 || m_saida !== 3'd3) begin
         errors++; $display("FAIL mealy_en0 got st=%0d out=%0d exp 0/3", m_estado, m_saida);
      end
   endtask

   initial begin
      reset = 1'b0;
      en = 0; a = 0; cfg_we = 0; cfg_addr = 0; cfg_next = 0; cfg_out = 0; cfg_clr = 0; err_clr = 0;
      m_en = 0; m_a = 0; m_we = 0; m_addr = 0; m_next = 0; m_out = 0; m_clr = 0; m_err_clr = 0;
      repeat (2) @(posedge clk);
      #3 reset = 1'b1;
      @(negedge clk);
      test_reset();
      test_program();
      test_unprog();
      test_dwell();
      test_collision();
      test_mealy();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout");
      $fatal(1);
   end

endmodule
